lzw_uart_tx: RTL and testbench

FPGA-side UART transmitter that returns LZW-compressed output bytes to the host serial link. Sits between the LZW output stage and the board TX pin, and drives the line into the host serial interface. A byte FIFO decouples the compressor from the line rate. Each byte is sent as 8N1, LSB first, with every bit held for 16 `sclk` cycles; `sclk` runs at 16× the baud rate (1.8432 MHz for 115200 baud).

---
 rtl/lzw_uart_tx.sv | 211 +++++++++++++++++++++
 tb/tb_lzw_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_uart_tx.sv
// UART transmitter with byte FIFO: 8N1 frames, LSB first, each bit held 16 sclk cycles.
// Optional even parity bit between data and stop when LZW_UART_TX_PARITY_EN is defined.
module lzw_uart_tx #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       sout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef LZW_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          overflow_reg;
    logic          push;
    logic          pop;

    state_t        state_reg;
    state_t        state_next;
    logic [3:0]    cnt16_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shreg_reg;
    logic          sout_reg;
    logic          sout_next;
    logic          shift;
    logic          tick;
    logic [7:0]    head_data;
`ifdef LZW_UART_TX_PARITY_EN
    logic          parity_reg;
`endif

    // Write decision uses full as seen before the edge, so a pop at the same edge cannot rescue it.
    assign push      = wr_en & ~full_reg;
    assign head_data = mem[rd_ptr_reg];
    assign tick      = (cnt16_reg == 4'd15);

    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg    <= count_next;
            full_reg     <= (count_next == FULL_CNT);
            empty_reg    <= (count_next == '0);
            overflow_reg <= overflow_reg | (wr_en & full_reg);
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!empty_reg) state_next = START;
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick && bit_cnt_reg == 3'd7) begin
`ifdef LZW_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef LZW_UART_TX_PARITY_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP:  if (tick) state_next = empty_reg ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // The line is registered, so each branch sets the level that will appear after this edge.
    always_comb begin
        pop       = 1'b0;
        shift     = 1'b0;
        sout_next = sout_reg;
        case (state_reg)
            IDLE: begin
                sout_next = 1'b1;
                if (!empty_reg) begin
                    pop       = 1'b1;
                    sout_next = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    sout_next = shreg_reg[0];
                    shift     = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == 3'd7) begin
`ifdef LZW_UART_TX_PARITY_EN
                        sout_next = parity_reg;
`else
                        sout_next = 1'b1;
`endif
                    end else begin
                        sout_next = shreg_reg[0];
                        shift     = 1'b1;
                    end
                end
            end
`ifdef LZW_UART_TX_PARITY_EN
            PARITY: if (tick) sout_next = 1'b1;
`endif
            STOP: begin
                if (tick && !empty_reg) begin
                    pop       = 1'b1;
                    sout_next = 1'b0;
                end
            end
            default: sout_next = 1'b1;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sout_reg    <= 1'b1;
            shreg_reg   <= '0;
            cnt16_reg   <= '0;
            bit_cnt_reg <= '0;
`ifdef LZW_UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            sout_reg <= sout_next;
            if (pop) begin
                shreg_reg <= head_data;
`ifdef LZW_UART_TX_PARITY_EN
                parity_reg <= ^head_data;
`endif
            end else if (shift) begin
                shreg_reg <= {1'b0, shreg_reg[7:1]};
            end
            if (state_reg == IDLE || state_next != state_reg) begin
                cnt16_reg <= '0;
            end else begin
                cnt16_reg <= cnt16_reg + 4'd1;
            end
            if (state_reg != DATA) begin
                bit_cnt_reg <= '0;
            end else if (tick) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign overflow = overflow_reg;
    assign sout     = sout_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_lzw_uart_tx.sv
// Directed bench for lzw_uart_tx: waveform timing, FIFO limits, reset abort, wrap-around.
module tb_lzw_uart_tx;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef LZW_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * 16;

    logic       sclk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       sout;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] rx_q [$];
    logic [7:0] wave_bytes [4];

    lzw_uart_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .din      (din),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .sout     (sout)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Level of frame bit k: 0 start, 1..8 data LSB first, then optional parity, then stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef LZW_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Receiver: samples each bit mid-cell; frames touched by reset are discarded.
    initial begin : rx_proc
        logic [7:0] b;
        logic       abort;
        logic       stop_bit;
        logic       par_bit;
        forever begin
            @(negedge sclk);
            if (rst === 1'b0 && sout === 1'b0) begin
                abort    = 1'b0;
                b        = '0;
                stop_bit = 1'b0;
                par_bit  = 1'b0;
                for (int c = 1; c <= 8 + 16 * (NBITS - 1); c++) begin
                    @(negedge sclk);
                    if (rst !== 1'b0) abort = 1'b1;
                    if (c >= 24 && ((c - 8) % 16) == 0) begin
                        if ((c - 8) / 16 <= 8) b[(c - 8) / 16 - 1] = sout;
                        else if ((c - 8) / 16 == NBITS - 1) stop_bit = sout;
                        else par_bit = sout;
                    end
                end
                if (!abort) begin
                    $display("[TB] rx byte 0x%02h", b);
                    rx_q.push_back(b);
                    check("rx_stop_bit", stop_bit, 1);
`ifdef LZW_UART_TX_PARITY_EN
                    check("rx_parity_bit", par_bit, ^b);
`endif
                end
            end
        end
    end

    task automatic put_byte(input logic [7:0] b);
        din   = b;
        wr_en = 1'b1;
        @(negedge sclk);
        wr_en = 1'b0;
    endtask

    // Called at the first negedge after the start bit begins.
    task automatic check_wave(input string tag, input int nbytes);
        int errs;
        int busy_cnt;
        busy_cnt = 0;
        for (int f = 0; f < nbytes; f++) begin
            for (int k = 0; k < NBITS; k++) begin
                errs = 0;
                for (int c = 0; c < 16; c++) begin
                    if (sout !== frame_bit(wave_bytes[f], k)) errs++;
                    if (busy === 1'b1) busy_cnt++;
                    @(negedge sclk);
                end
                check($sformatf("%s_f%0d_bit%0d_errs", tag, f, k), errs, 0);
            end
        end
        check({tag, "_busy_cycles"}, busy_cnt, nbytes * FRAME);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_sout_idle"}, sout, 1);
        check({tag, "_empty_end"}, empty, 1);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge sclk);
            c++;
        end
        check({tag, "_rx_count"}, rx_q.size(), n);
    endtask

    initial begin : main
        int errs;
        int low_cnt;
        int busy_cnt;
        int idx;
        int cyc;

        rst   = 1'b1;
        din   = '0;
        wr_en = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst_sout", sout, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge sclk);

        // Single 0xA5: line 0,1,0,1,0,0,1,0,1,1
        wave_bytes[0] = 8'hA5;
        put_byte(8'hA5);
        check("a5_e0_empty", empty, 0);
        check("a5_e0_sout", sout, 1);
        check("a5_e0_busy", busy, 0);
        @(negedge sclk);
        check("a5_e1_empty", empty, 1);
        check_wave("a5", 1);
        check("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("a5_rx_byte", rx_q[0], 8'hA5);

        // Back-to-back 0x00, 0xFF
        rx_q.delete();
        wave_bytes[0] = 8'h00;
        wave_bytes[1] = 8'hFF;
        din   = 8'h00;
        wr_en = 1'b1;
        @(negedge sclk);
        din   = 8'hFF;
        @(negedge sclk);
        wr_en = 1'b0;
        check_wave("b2b", 2);
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("b2b_rx_byte0", rx_q[0], 8'h00);
            check("b2b_rx_byte1", rx_q[1], 8'hFF);
        end

        // DEPTH+2 consecutive writes: last one rejected
        rx_q.delete();
        for (int j = 0; j < DEPTH + 2; j++) begin
            din   = 8'(16 + j);
            wr_en = 1'b1;
            @(negedge sclk);
            if (j == DEPTH - 1) check("fill_not_full", full, 0);
            if (j == DEPTH) begin
                check("fill_full", full, 1);
                check("fill_no_ovf_yet", overflow, 0);
            end
            if (j == DEPTH + 1) begin
                check("fill_overflow", overflow, 1);
                check("fill_still_full", full, 1);
            end
        end
        wr_en = 1'b0;
        wait_rx("fill", DEPTH + 1, (DEPTH + 3) * FRAME);
        errs = 0;
        for (int j = 0; j < rx_q.size() && j < DEPTH + 1; j++)
            if (rx_q[j] !== 8'(16 + j)) errs++;
        check("fill_order_errs", errs, 0);
        repeat (2 * FRAME) @(negedge sclk);
        check("fill_no_extra_frame", rx_q.size(), DEPTH + 1);
        check("fill_overflow_sticky", overflow, 1);
        check("fill_busy_end", busy, 0);
        check("fill_empty_end", empty, 1);

        // Reset during data bit 4 with three bytes queued
        rx_q.delete();
        for (int j = 0; j < 4; j++) begin
            din   = 8'h11 * 8'(j + 1);
            wr_en = 1'b1;
            @(negedge sclk);
        end
        wr_en = 1'b0;
        repeat (84) @(negedge sclk);
        check("prerst_busy", busy, 1);
        check("prerst_empty", empty, 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_sout", sout, 1);
        check("midrst_empty", empty, 1);
        check("midrst_busy", busy, 0);
        check("midrst_full", full, 0);
        check("midrst_overflow", overflow, 0);
        repeat (2) @(negedge sclk);
        rst = 1'b0;
        low_cnt  = 0;
        busy_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge sclk);
            if (sout !== 1'b1) low_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        check("postrst_sout_low_cycles", low_cnt, 0);
        check("postrst_busy_cycles", busy_cnt, 0);
        check("postrst_rx_count", rx_q.size(), 0);
        check("postrst_empty", empty, 1);
        wave_bytes[0] = 8'h3C;
        put_byte(8'h3C);
        check("postrst_e0_empty", empty, 0);
        @(negedge sclk);
        check("postrst_e1_empty", empty, 1);
        check_wave("postrst", 1);
        check("postrst_rx_count2", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("postrst_rx_byte", rx_q[0], 8'h3C);

        // Wrap-around: 3*DEPTH bytes with writes gated by ~full
        rx_q.delete();
        idx = 0;
        cyc = 0;
        while (idx < 3 * DEPTH && cyc < 3 * DEPTH * FRAME + 1000) begin
            if (!full) begin
                din   = 8'(idx * 37 + 5);
                wr_en = 1'b1;
                idx++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge sclk);
            cyc++;
        end
        wr_en = 1'b0;
        check("wrap_all_written", idx, 3 * DEPTH);
        wait_rx("wrap", 3 * DEPTH, 3 * DEPTH * FRAME + 1000);
        errs = 0;
        for (int j = 0; j < rx_q.size() && j < 3 * DEPTH; j++)
            if (rx_q[j] !== 8'(j * 37 + 5)) errs++;
        check("wrap_order_errs", errs, 0);
        check("wrap_overflow", overflow, 0);
        repeat (FRAME) @(negedge sclk);

`ifdef LZW_UART_TX_PARITY_EN
        // 0x07 carries parity 1, 0x03 parity 0
        wave_bytes[0] = 8'h07;
        put_byte(8'h07);
        @(negedge sclk);
        check_wave("par07", 1);
        wave_bytes[0] = 8'h03;
        put_byte(8'h03);
        @(negedge sclk);
        check_wave("par03", 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
